seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to the result cycle with a saturated quotient.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;   // dividend bits shift out the top while quotient bits shift in
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             borrow;
  logic             nonneg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // WIDTH+1-bit trial subtraction: a set top bit of the shifted remainder
  // already guarantees it exceeds any WIDTH-bit divisor.
  always_comb begin
    shifted  = {rem_q, dq_q[WIDTH-1]};
    {borrow, trial} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvs_q};
    nonneg   = shifted[WIDTH] | ~borrow;
    rem_next = nonneg ? trial : shifted[WIDTH-1:0];
    quo_next = {dq_q[WIDTH-2:0], nonneg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvs_q       <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= FIN;
            end else begin
              dvs_q       <= divisor;
              dq_q        <= dividend;
              rem_q       <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          dq_q  <= quo_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= quo_next;
            remainder <= rem_next;
            state     <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == FIN);
  assign fsm_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a vector table run back-to-back, plus
// start-while-busy, mid-run reset and reset-state sequences.
module tb_seq_divider;

  localparam int W = 32;
  localparam int BUDGET = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[13];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called just after a negedge with the DUT idle; returns one negedge after
  // the done cycle, which is again an idle cycle, so calls chain back-to-back.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int glitch, input string name);
    int got;
    logic gap;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    got = -1;
    gap = 1'b0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= BUDGET; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = c;
        break;
      end
      if (!busy) gap = 1'b1;
      if (c == glitch) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
      end
    end
    check({name, " latency"}, 64'(got), (b == '0) ? 64'd0 : 64'(W));
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " quotient"}, 64'(quotient), 64'(eq));
    check({name, " remainder"}, 64'(remainder), 64'(er));
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    if (b != '0) check({name, " busy_held"}, 64'(gap), 64'd0);
    hq = quotient;
    hr = remainder;
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
    check({name, " hold"}, {quotient, remainder}, {hq, hr});
  endtask

  initial begin
    int dcount;
    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[2]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[4]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[6]  = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0};
    vecs[7]  = '{32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
    vecs[8]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[9]  = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
    vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[11] = '{32'hFFFFFFFE,   32'hFFFFFFFF,   32'd0,          32'hFFFFFFFE,   1'b0};
    vecs[12] = '{32'd12345,      32'd12345,      32'd1,          32'd0,          1'b0};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset outputs", {quotient, remainder}, 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    check("reset state", 64'(fsm_state), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z, -1,
             $sformatf("vec%0d", i));

    // New operands pulsed at edge N+10 must not disturb the running 100/7.
    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9, "start_while_busy");

    // Reset at edge N+15 of a running division.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst busy", 64'(busy), 64'd0);
    check("midrun_rst done", 64'(done), 64'd0);
    check("midrun_rst outputs", {quotient, remainder}, 64'd0);
    check("midrun_rst div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrun_rst no_done", 64'(dcount), 64'd0);
    do_div(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, -1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
